// File: rtl/pipeline_pkg.sv
// Shared types for the pipeline boundaries around the memory stage.
// Execute, Memory and Writeback all agree on these bundles.
package pipeline_pkg;

    localparam int DATA_W      = 16;
    localparam int MEM_LAT_DEF = 2;

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    typedef struct packed {
        logic [3:0]        rs;
        logic [3:0]        rt;
        logic [3:0]        rd;
        logic [DATA_W-1:0] alu_result;
        logic              RegDst;
        logic              RegWrite;
        logic              MemtoReg;
    } wb_ctl_t;

    typedef struct packed {
        wb_ctl_t           ctl;
        logic [DATA_W-1:0] read_data;
    } mem_wb_t;

    typedef struct packed {
        wb_ctl_t           ctl;
        logic [DATA_W-1:0] write_data;
        logic              MemRead;
        logic              MemWrite;
    } ex_mem_t;

    function automatic int cnt_width(input int lat);
        return (lat > 1) ? $clog2(lat) : 1;
    endfunction

endpackage

// File: rtl/data_memory.sv
// Word-addressed data RAM: registered read, gated write, async clear.
// The read register returns zero whenever no read is requested.
module data_memory
    import pipeline_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
        end else begin
            r_rdata <= i_re ? r_mem[i_addr] : '0;
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/memory_stage.sv
// MEM stage: multi-cycle loads/stores, single-cycle pass-through otherwise.
// Holds upstream with mem_busy and feeds bubbles to Writeback meanwhile.
module memory_stage
    import pipeline_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DEPTH   = 256,
    parameter int MEM_LAT = MEM_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              flush,
    input  logic [3:0]        rs_i,
    input  logic [3:0]        rt_i,
    input  logic [3:0]        rd_i,
    input  logic [DATA_W-1:0] alu_result_i,
    input  logic [DATA_W-1:0] write_data_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic              RegDst_i,
    input  logic              RegWrite_i,
    input  logic              MemtoReg_i,
    output logic              mem_busy,
    output logic [3:0]        rs,
    output logic [3:0]        rt,
    output logic [3:0]        rd,
    output logic [DATA_W-1:0] alu_result,
    output logic [DATA_W-1:0] read_data,
    output logic              RegDst,
    output logic              RegWrite,
    output logic              MemtoReg,
    output logic              stall
);

    localparam int CNT_W = cnt_width(MEM_LAT);

    state_t            r_state;
    state_t            w_state_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_next;
    ex_mem_t           r_hold;
    wb_ctl_t           r_out;
    logic              r_stall;
    ex_mem_t           w_in;
    mem_wb_t           w_wb;
    logic              w_accept;
    logic              w_is_mem;
    logic              w_done;
    logic              w_we;
    logic              w_re;
    logic [DATA_W-1:0] w_rdata;

    always_comb begin
        w_in                = '0;
        w_in.ctl.rs         = rs_i;
        w_in.ctl.rt         = rt_i;
        w_in.ctl.rd         = rd_i;
        w_in.ctl.alu_result = alu_result_i;
        w_in.ctl.RegDst     = RegDst_i;
        w_in.ctl.RegWrite   = RegWrite_i;
        w_in.ctl.MemtoReg   = MemtoReg_i;
        w_in.write_data     = write_data_i;
        w_in.MemRead        = MemRead_i;
        w_in.MemWrite       = MemWrite_i;
    end

    assign w_accept = (r_state == IDLE) && in_valid && !flush;
    assign w_is_mem = MemRead_i || MemWrite_i;
    assign w_done   = (r_state == ACCESS) && !flush && (r_cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        unique case (r_state)
            IDLE: begin
                if (w_accept && w_is_mem) begin
                    w_state_next = ACCESS;
                    w_cnt_next   = CNT_W'(MEM_LAT - 1);
                end
            end
            ACCESS: begin
                if (flush) begin
                    w_state_next = IDLE;
                    w_cnt_next   = '0;
                end else if (r_cnt != '0) begin
                    w_cnt_next = r_cnt - 1'b1;
                end else begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold <= '0;
        end else if (w_accept && w_is_mem) begin
            r_hold <= w_in;
        end
    end

    // Bubbles only clear RegWrite; the other fields keep their last values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out   <= '0;
            r_stall <= 1'b1;
        end else if (w_accept && !w_is_mem) begin
            r_out   <= w_in.ctl;
            r_stall <= 1'b0;
        end else if (w_done) begin
            r_out   <= r_hold.ctl;
            r_stall <= 1'b0;
        end else begin
            r_out.RegWrite <= 1'b0;
            r_stall        <= 1'b1;
        end
    end

    // A combined read+write request behaves as a store.
    assign w_we = w_done && r_hold.MemWrite;
    assign w_re = w_done && r_hold.MemRead && !r_hold.MemWrite;

    data_memory #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_dmem (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_we),
        .i_re    (w_re),
        .i_addr  (r_hold.ctl.alu_result[ADDR_W-1:0]),
        .i_wdata (r_hold.write_data),
        .o_rdata (w_rdata)
    );

    assign w_wb.ctl       = r_out;
    assign w_wb.read_data = w_rdata;

    assign mem_busy   = (r_state == ACCESS);
    assign rs         = w_wb.ctl.rs;
    assign rt         = w_wb.ctl.rt;
    assign rd         = w_wb.ctl.rd;
    assign alu_result = w_wb.ctl.alu_result;
    assign read_data  = w_wb.read_data;
    assign RegDst     = w_wb.ctl.RegDst;
    assign RegWrite   = w_wb.ctl.RegWrite;
    assign MemtoReg   = w_wb.ctl.MemtoReg;
    assign stall      = r_stall;

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: per-cycle vector table plus
// hand-written reset and MEM_LAT=1 sequences.
module tb_memory_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid, flush;
    logic [3:0]  rs_i, rt_i, rd_i;
    logic [15:0] alu_result_i, write_data_i;
    logic        MemRead_i, MemWrite_i, RegDst_i, RegWrite_i, MemtoReg_i;

    logic        mem_busy, RegDst, RegWrite, MemtoReg, stall;
    logic [3:0]  rs, rt, rd;
    logic [15:0] alu_result, read_data;

    logic        mem_busy_1, RegDst_1, RegWrite_1, MemtoReg_1, stall_1;
    logic [3:0]  rs_1, rt_1, rd_1;
    logic [15:0] alu_result_1, read_data_1;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    memory_stage #(.ADDR_W(8), .DEPTH(256), .MEM_LAT(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .flush(flush),
        .rs_i(rs_i), .rt_i(rt_i), .rd_i(rd_i),
        .alu_result_i(alu_result_i), .write_data_i(write_data_i),
        .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
        .RegDst_i(RegDst_i), .RegWrite_i(RegWrite_i),
        .MemtoReg_i(MemtoReg_i),
        .mem_busy(mem_busy), .rs(rs), .rt(rt), .rd(rd),
        .alu_result(alu_result), .read_data(read_data),
        .RegDst(RegDst), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
        .stall(stall)
    );

    memory_stage #(.ADDR_W(8), .DEPTH(256), .MEM_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .flush(flush),
        .rs_i(rs_i), .rt_i(rt_i), .rd_i(rd_i),
        .alu_result_i(alu_result_i), .write_data_i(write_data_i),
        .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
        .RegDst_i(RegDst_i), .RegWrite_i(RegWrite_i),
        .MemtoReg_i(MemtoReg_i),
        .mem_busy(mem_busy_1), .rs(rs_1), .rt(rt_1), .rd(rd_1),
        .alu_result(alu_result_1), .read_data(read_data_1),
        .RegDst(RegDst_1), .RegWrite(RegWrite_1), .MemtoReg(MemtoReg_1),
        .stall(stall_1)
    );

    typedef struct {
        logic        v, f, mr, mw, rw, rdst, m2r;
        logic [3:0]  rs, rt, rd;
        logic [15:0] alu, wd;
        logic        es, erw, erdst, em2r;
        logic [3:0]  ers, ert, erd;
        logic [15:0] ealu, erdata;
        logic        ebusy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic v, f, mr, mw, rw, rdst, m2r,
        input logic [3:0] rs, rt, rd,
        input logic [15:0] alu, wd,
        input logic es, erw, erdst, em2r,
        input logic [3:0] ers, ert, erd,
        input logic [15:0] ealu, erdata,
        input logic ebusy
    );
        vec_t t;
        t.v = v; t.f = f; t.mr = mr; t.mw = mw;
        t.rw = rw; t.rdst = rdst; t.m2r = m2r;
        t.rs = rs; t.rt = rt; t.rd = rd;
        t.alu = alu; t.wd = wd;
        t.es = es; t.erw = erw; t.erdst = erdst; t.em2r = em2r;
        t.ers = ers; t.ert = ert; t.erd = erd;
        t.ealu = ealu; t.erdata = erdata; t.ebusy = ebusy;
        return t;
    endfunction

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(
        input logic v, f, mr, mw, rw, rdst, m2r,
        input logic [3:0] a_rs, a_rt, a_rd,
        input logic [15:0] alu, wd
    );
        in_valid = v; flush = f; MemRead_i = mr; MemWrite_i = mw;
        RegWrite_i = rw; RegDst_i = rdst; MemtoReg_i = m2r;
        rs_i = a_rs; rt_i = a_rt; rd_i = a_rd;
        alu_result_i = alu; write_data_i = wd;
    endtask

    task automatic idle_in();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0);
    endtask

    function automatic logic [63:0] obs();
        return {15'd0, stall, RegWrite, RegDst, MemtoReg, rs, rt, rd,
                alu_result, read_data, mem_busy};
    endfunction

    function automatic logic [63:0] expv(input vec_t t);
        return {15'd0, t.es, t.erw, t.erdst, t.em2r, t.ers, t.ert, t.erd,
                t.ealu, t.erdata, t.ebusy};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // R-type, bubbles, flush
        tbl.push_back(mk(1,0,0,0,1,1,0, 1,2,3,16'h1234,0, 0,1,1,0, 1,2,3,16'h1234,0,0));
        tbl.push_back(mk(1,0,0,0,1,1,0, 6,7,5,16'hFFFF,0, 0,1,1,0, 6,7,5,16'hFFFF,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0, 0,0,0,16'h0,0, 1,0,1,0, 6,7,5,16'hFFFF,0,0));
        tbl.push_back(mk(1,1,0,0,1,1,0, 8,9,9,16'h5555,0, 1,0,1,0, 6,7,5,16'hFFFF,0,0));
        // store BEEF -> 0x0A, R-type offered while busy is ignored
        tbl.push_back(mk(1,0,0,1,0,0,0, 2,10,0,16'h000A,16'hBEEF, 1,0,1,0, 6,7,5,16'hFFFF,0,1));
        tbl.push_back(mk(1,0,0,0,1,1,0, 11,12,7,16'h7777,0, 1,0,1,0, 6,7,5,16'hFFFF,0,1));
        tbl.push_back(mk(0,0,0,0,0,0,0, 0,0,0,16'h0,0, 0,0,0,0, 2,10,0,16'h000A,0,0));
        // load from 0x010A (wraps to 0x0A)
        tbl.push_back(mk(1,0,1,0,1,0,1, 4,1,8,16'h010A,0, 1,0,0,0, 2,10,0,16'h000A,0,1));
        tbl.push_back(mk(0,0,0,0,0,0,0, 0,0,0,16'h0,0, 1,0,0,0, 2,10,0,16'h000A,0,1));
        tbl.push_back(mk(0,0,0,0,0,0,0, 0,0,0,16'h0,0, 0,1,0,1, 4,1,8,16'h010A,16'hBEEF,0));
        tbl.push_back(mk(0,0,0,0,0,0,0, 0,0,0,16'h0,0, 1,0,0,1, 4,1,8,16'h010A,0,0));
        // store 0x1111 -> 0x20 aborted by flush, then load 0x20
        tbl.push_back(mk(1,0,0,1,0,0,0, 3,3,0,16'h0020,16'h1111, 1,0,0,1, 4,1,8,16'h010A,0,1));
        tbl.push_back(mk(0,1,0,0,0,0,0, 0,0,0,16'h0,0, 1,0,0,1, 4,1,8,16'h010A,0,0));
        tbl.push_back(mk(1,0,1,0,1,0,1, 5,11,2,16'h0020,0, 1,0,0,1, 4,1,8,16'h010A,0,1));
        tbl.push_back(mk(0,0,0,0,0,0,0, 0,0,0,16'h0,0, 1,0,0,1, 4,1,8,16'h010A,0,1));
        tbl.push_back(mk(0,0,0,0,0,0,0, 0,0,0,16'h0,0, 0,1,0,1, 5,11,2,16'h0020,0,0));
        // read+write together acts as store of 0x7777 -> 0x0A
        tbl.push_back(mk(1,0,1,1,0,0,0, 1,13,1,16'h000A,16'h7777, 1,0,0,1, 5,11,2,16'h0020,0,1));
        tbl.push_back(mk(0,0,0,0,0,0,0, 0,0,0,16'h0,0, 1,0,0,1, 5,11,2,16'h0020,0,1));
        tbl.push_back(mk(0,0,0,0,0,0,0, 0,0,0,16'h0,0, 0,0,0,0, 1,13,1,16'h000A,0,0));
        tbl.push_back(mk(1,0,1,0,1,0,1, 7,14,4,16'hFF0A,0, 1,0,0,0, 1,13,1,16'h000A,0,1));
        tbl.push_back(mk(0,0,0,0,0,0,0, 0,0,0,16'h0,0, 1,0,0,0, 1,13,1,16'h000A,0,1));
        tbl.push_back(mk(0,0,0,0,0,0,0, 0,0,0,16'h0,0, 0,1,0,1, 7,14,4,16'hFF0A,16'h7777,0));
        // flush on the accept edge of a store: nothing captured
        tbl.push_back(mk(1,1,0,1,0,0,0, 9,15,9,16'h0030,16'hAAAA, 1,0,0,1, 7,14,4,16'hFF0A,0,0));
        tbl.push_back(mk(1,0,1,0,1,0,1, 2,5,6,16'h0030,0, 1,0,0,1, 7,14,4,16'hFF0A,0,1));
        tbl.push_back(mk(0,0,0,0,0,0,0, 0,0,0,16'h0,0, 1,0,0,1, 7,14,4,16'hFF0A,0,1));
        tbl.push_back(mk(0,0,0,0,0,0,0, 0,0,0,16'h0,0, 0,1,0,1, 2,5,6,16'h0030,0,0));

        idle_in();
        rst = 1'b1;
        tick();
        tick();
        check("reset_state", obs(), 64'h0001_0000_0000_0000);
        rst = 1'b0;

        foreach (tbl[i]) begin
            drive(tbl[i].v, tbl[i].f, tbl[i].mr, tbl[i].mw, tbl[i].rw,
                  tbl[i].rdst, tbl[i].m2r, tbl[i].rs, tbl[i].rt, tbl[i].rd,
                  tbl[i].alu, tbl[i].wd);
            tick();
            check($sformatf("row%0d", i), obs(), expv(tbl[i]));
        end

        // async reset mid-simulation, then memory reads back zero
        idle_in();
        rst = 1'b1;
        #1;
        check("rst_async", {45'd0, stall, RegWrite, mem_busy, alu_result},
              {45'd0, 1'b1, 1'b0, 1'b0, 16'h0000});
        tick();
        rst = 1'b0;
        drive(1,0,1,0,1,0,1, 4,0,2,16'h0005,0);
        tick();
        idle_in();
        tick();
        tick();
        check("rst_mem5", {stall, rd, read_data}, {1'b0, 4'd2, 16'h0000});
        drive(1,0,1,0,1,0,1, 4,0,2,16'h000A,0);
        tick();
        idle_in();
        tick();
        tick();
        check("rst_memA", {stall, rd, read_data}, {1'b0, 4'd2, 16'h0000});

        // reset asserted while a load is in ACCESS
        drive(1,0,0,1,0,0,0, 1,0,0,16'h0040,16'h4444);
        tick();
        idle_in();
        tick();
        tick();
        drive(1,0,1,0,1,0,1, 3,0,7,16'h0040,0);
        tick();
        idle_in();
        check("ld_busy", {63'd0, mem_busy}, 64'd1);
        rst = 1'b1;
        #1;
        check("rst_in_access", obs(), 64'h0001_0000_0000_0000);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("no_completion%0d", k),
                  {stall, RegWrite, read_data}, {1'b1, 1'b0, 16'h0000});
        end

        // MEM_LAT=1 instance: store, load, back-to-back R-type
        drive(1,0,0,1,0,0,0, 1,0,0,16'h0003,16'h1357);
        tick();
        check("l1_st_busy", {mem_busy_1, stall_1}, {1'b1, 1'b1});
        idle_in();
        tick();
        check("l1_st_done", {mem_busy_1, stall_1}, {1'b0, 1'b0});
        drive(1,0,1,0,1,0,1, 4,0,6,16'h0003,0);
        tick();
        check("l1_ld_busy", {mem_busy_1, stall_1}, {1'b1, 1'b1});
        tick();
        check("l1_ld_out", {stall_1, RegWrite_1, rd_1, read_data_1, mem_busy_1},
              {1'b0, 1'b1, 4'd6, 16'h1357, 1'b0});
        drive(1,0,0,0,1,1,0, 2,3,9,16'h00AB,0);
        tick();
        check("l1_rtype", {stall_1, RegWrite_1, rd_1, alu_result_1,
                           read_data_1, mem_busy_1},
              {1'b0, 1'b1, 4'd9, 16'h00AB, 16'h0000, 1'b0});
        idle_in();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
